// File: rtl/frame_sync_pkg.sv
// rtl/frame_sync_pkg.sv - shared video timing constants and INT state encoding
package frame_sync_pkg;

  localparam int VPERIOD_DEF   = 320;
  localparam int VBLNK_BEG_DEF = 0;
  localparam int VSYNC_BEG_DEF = 8;
  localparam int VSYNC_END_DEF = 12;
  localparam int VBLNK_END_DEF = 32;
  localparam int VPIX_BEG_DEF  = 80;
  localparam int VPIX_END_DEF  = 272;
  localparam int VINT_LINE_DEF = 319;
  localparam int INT_LEN_DEF   = 64;

  localparam int LINE_W    = 9;
  localparam int INT_CNT_W = 7;

  typedef enum logic {
    INT_IDLE   = 1'b0,
    INT_ACTIVE = 1'b1
  } int_state_e;

endpackage

// File: rtl/frame_sync_if.sv
// rtl/frame_sync_if.sv - strobe inputs and vertical timing outputs of frame_sync
interface frame_sync_if;
  import frame_sync_pkg::*;

  logic              cend;
  logic              line_start;
  logic              hsync_start;
  logic              hint_start;
  logic              int_ack;
  logic              vblank;
  logic              vsync;
  logic              vpix;
  logic              int_n;
  logic              frame_start;
  logic [LINE_W-1:0] line_cnt;

  modport master (
    output cend, line_start, hsync_start, hint_start, int_ack,
    input  vblank, vsync, vpix, int_n, frame_start, line_cnt
  );

  modport slave (
    input  cend, line_start, hsync_start, hint_start, int_ack,
    output vblank, vsync, vpix, int_n, frame_start, line_cnt
  );

endinterface

// File: rtl/frame_sync_int_gen.sv
// rtl/frame_sync_int_gen.sv - Z80 INT pulse: starts on trigger, ends on ack or after INT_LEN cend strobes
module int_gen
  import frame_sync_pkg::*;
#(
  parameter int INT_LEN = INT_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  input  logic ack,
  input  logic cend,
  output logic int_n
);

  int_state_e           state;
  logic [INT_CNT_W-1:0] width;
  logic                 timeout;

  assign timeout = cend && (width == INT_CNT_W'(INT_LEN - 1));

  // trigger has priority over ack and timeout so a retrigger always restarts the pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INT_IDLE;
      width <= '0;
      int_n <= 1'b1;
    end else begin
      case (state)
        INT_IDLE: begin
          if (trigger) begin
            state <= INT_ACTIVE;
            width <= '0;
            int_n <= 1'b0;
          end
        end
        INT_ACTIVE: begin
          if (trigger) begin
            width <= '0;
            int_n <= 1'b0;
          end else if (ack || timeout) begin
            state <= INT_IDLE;
            width <= '0;
            int_n <= 1'b1;
          end else if (cend) begin
            width <= width + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/frame_sync.sv
// rtl/frame_sync.sv - vertical line counter, window flags, frame strobe and frame INT
module frame_sync
  import frame_sync_pkg::*;
#(
  parameter int VPERIOD   = VPERIOD_DEF,
  parameter int VBLNK_BEG = VBLNK_BEG_DEF,
  parameter int VSYNC_BEG = VSYNC_BEG_DEF,
  parameter int VSYNC_END = VSYNC_END_DEF,
  parameter int VBLNK_END = VBLNK_END_DEF,
  parameter int VPIX_BEG  = VPIX_BEG_DEF,
  parameter int VPIX_END  = VPIX_END_DEF,
  parameter int VINT_LINE = VINT_LINE_DEF,
  parameter int INT_LEN   = INT_LEN_DEF
) (
  input  logic         clk,
  input  logic         rst,
  frame_sync_if.slave  bus
);

  logic [LINE_W-1:0] line_cnt;
  logic              vblank;
  logic              vsync;
  logic              vpix;
  logic              frame_start;
  logic              trigger;
  logic              int_n;

  // flags compare against the pre-increment count when line_start coincides
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_cnt    <= '0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
      vsync       <= 1'b0;
      vpix        <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (bus.line_start) begin
        if (line_cnt == LINE_W'(VPERIOD - 1)) begin
          line_cnt    <= '0;
          frame_start <= 1'b1;
        end else begin
          line_cnt <= line_cnt + 1'b1;
        end
      end
      if (bus.hsync_start) begin
        if (line_cnt == LINE_W'(VBLNK_BEG))      vblank <= 1'b1;
        else if (line_cnt == LINE_W'(VBLNK_END)) vblank <= 1'b0;
        if (line_cnt == LINE_W'(VSYNC_BEG))      vsync <= 1'b1;
        else if (line_cnt == LINE_W'(VSYNC_END)) vsync <= 1'b0;
        if (line_cnt == LINE_W'(VPIX_BEG))       vpix <= 1'b1;
        else if (line_cnt == LINE_W'(VPIX_END))  vpix <= 1'b0;
      end
    end
  end

  assign trigger = bus.hint_start && (line_cnt == LINE_W'(VINT_LINE));

  int_gen #(
    .INT_LEN (INT_LEN)
  ) u_int_gen (
    .clk     (clk),
    .rst     (rst),
    .trigger (trigger),
    .ack     (bus.int_ack),
    .cend    (bus.cend),
    .int_n   (int_n)
  );

  assign bus.line_cnt    = line_cnt;
  assign bus.vblank      = vblank;
  assign bus.vsync       = vsync;
  assign bus.vpix        = vpix;
  assign bus.frame_start = frame_start;
  assign bus.int_n       = int_n;

endmodule

// File: tb/tb_frame_sync.sv
// tb/tb_frame_sync.sv - directed and randomized checks of frame_sync against a line/INT model
module tb_frame_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_sync_if bus ();

  frame_sync dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic cyc(input logic ls, input logic hs, input logic hi, input logic ack, input logic ce);
    bus.line_start  = ls;
    bus.hsync_start = hs;
    bus.hint_start  = hi;
    bus.int_ack     = ack;
    bus.cend        = ce;
    @(negedge clk);
    bus.line_start  = 1'b0;
    bus.hsync_start = 1'b0;
    bus.hint_start  = 1'b0;
    bus.int_ack     = 1'b0;
    bus.cend        = 1'b0;
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // count cend strobes accepted while int_n is low, bounded
  task automatic count_int(output int cnt);
    cnt = 0;
    while (bus.int_n === 1'b0 && cnt < 300) begin
      cyc(0, 0, 0, 0, 1);
      cnt++;
      cyc(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_reset;
    logic [13:0] got;
    rst = 1'b1;
    #1;
    got = {bus.line_cnt, bus.vblank, bus.vsync, bus.vpix, bus.int_n, bus.frame_start};
    n_cmp++;
    if (got !== {9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", got, {9'd0, 5'b00010});
    end
    do_reset();
    n_cmp++;
    if (bus.int_n !== 1'b1 || bus.line_cnt !== 9'd0) begin
      n_err++;
      $display("FAIL reset_release: int_n=%b line_cnt=%0d want 1/0", bus.int_n, bus.line_cnt);
    end
  endtask

  task automatic test_frame_wrap;
    int pulses = 0;
    int at = -1;
    do_reset();
    for (int i = 1; i <= 320; i++) begin
      cyc(1, 0, 0, 0, 0);
      if (bus.frame_start === 1'b1) begin
        pulses++;
        at = i;
      end
    end
    n_cmp++;
    if (bus.line_cnt !== 9'd0) begin
      n_err++;
      $display("FAIL wrap_line_cnt: got %0d want 0", bus.line_cnt);
    end
    n_cmp++;
    if (pulses !== 1 || at !== 320) begin
      n_err++;
      $display("FAIL wrap_frame_start: pulses %0d at %0d want 1 at 320", pulses, at);
    end
    cyc(0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.frame_start !== 1'b0) begin
      n_err++;
      $display("FAIL frame_start_width: got %b want 0", bus.frame_start);
    end
  endtask

  task automatic test_flags;
    do_reset();
    lines(7);
    cyc(0, 1, 0, 0, 0);
    n_cmp++;
    if (bus.vsync !== 1'b0) begin n_err++; $display("FAIL vsync_line7: got %b want 0", bus.vsync); end
    lines(1);
    n_cmp++;
    if (bus.vsync !== 1'b0) begin n_err++; $display("FAIL vsync_hold8: got %b want 0", bus.vsync); end
    cyc(0, 1, 0, 0, 0);
    n_cmp++;
    if (bus.vsync !== 1'b1) begin n_err++; $display("FAIL vsync_line8: got %b want 1", bus.vsync); end
    lines(4);
    cyc(0, 1, 0, 0, 0);
    n_cmp++;
    if (bus.vsync !== 1'b0) begin n_err++; $display("FAIL vsync_line12: got %b want 0", bus.vsync); end
    lines(20);
    cyc(0, 1, 0, 0, 0);
    n_cmp++;
    if (bus.vblank !== 1'b0) begin n_err++; $display("FAIL vblank_line32: got %b want 0", bus.vblank); end
    lines(48);
    cyc(0, 1, 0, 0, 0);
    n_cmp++;
    if (bus.vpix !== 1'b1) begin n_err++; $display("FAIL vpix_line80: got %b want 1", bus.vpix); end
    lines(192);
    n_cmp++;
    if (bus.vpix !== 1'b1) begin n_err++; $display("FAIL vpix_hold272: got %b want 1", bus.vpix); end
    cyc(0, 1, 0, 0, 0);
    n_cmp++;
    if (bus.vpix !== 1'b0) begin n_err++; $display("FAIL vpix_line272: got %b want 0", bus.vpix); end
    lines(48);
    cyc(0, 1, 0, 0, 0);
    n_cmp++;
    if (bus.vblank !== 1'b1) begin n_err++; $display("FAIL vblank_line0: got %b want 1", bus.vblank); end
    lines(7);
    cyc(1, 1, 0, 0, 0);
    n_cmp++;
    if (bus.vsync !== 1'b0 || bus.line_cnt !== 9'd8) begin
      n_err++;
      $display("FAIL coincident_7: vsync %b line %0d want 0/8", bus.vsync, bus.line_cnt);
    end
    cyc(1, 1, 0, 0, 0);
    n_cmp++;
    if (bus.vsync !== 1'b1) begin n_err++; $display("FAIL coincident_8: got %b want 1", bus.vsync); end
  endtask

  task automatic test_int_timeout;
    int cnt;
    do_reset();
    lines(318);
    cyc(0, 0, 1, 0, 0);
    n_cmp++;
    if (bus.int_n !== 1'b1) begin n_err++; $display("FAIL int_wrong_line: got %b want 1", bus.int_n); end
    lines(1);
    cyc(0, 0, 1, 0, 0);
    n_cmp++;
    if (bus.int_n !== 1'b0) begin n_err++; $display("FAIL int_start: got %b want 0", bus.int_n); end
    count_int(cnt);
    n_cmp++;
    if (cnt !== 64) begin n_err++; $display("FAIL int_timeout_len: got %0d want 64", cnt); end
  endtask

  task automatic test_int_ack;
    int cnt;
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1);
    n_cmp++;
    if (bus.int_n !== 1'b0) begin n_err++; $display("FAIL int_before_ack: got %b want 0", bus.int_n); end
    cyc(0, 0, 0, 1, 0);
    n_cmp++;
    if (bus.int_n !== 1'b1) begin n_err++; $display("FAIL int_ack: got %b want 1", bus.int_n); end
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1);
    n_cmp++;
    if (bus.int_n !== 1'b1) begin n_err++; $display("FAIL int_ack_idle: got %b want 1", bus.int_n); end
    cyc(0, 0, 1, 0, 0);
    count_int(cnt);
    n_cmp++;
    if (cnt !== 64) begin n_err++; $display("FAIL int_after_ack_len: got %0d want 64", cnt); end
  endtask

  task automatic test_int_collision;
    int cnt;
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 1, 0);
    n_cmp++;
    if (bus.int_n !== 1'b0) begin n_err++; $display("FAIL collision_int_n: got %b want 0", bus.int_n); end
    count_int(cnt);
    n_cmp++;
    if (cnt !== 64) begin n_err++; $display("FAIL collision_len: got %0d want 64", cnt); end
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 63; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1);
    n_cmp++;
    if (bus.int_n !== 1'b1) begin n_err++; $display("FAIL ack_timeout_same: got %b want 1", bus.int_n); end
  endtask

  task automatic test_reset_mid;
    cyc(0, 0, 1, 0, 0);
    lines(151);
    n_cmp++;
    if (bus.line_cnt !== 9'd150 || bus.int_n !== 1'b0) begin
      n_err++;
      $display("FAIL mid_setup: line %0d int_n %b want 150/0", bus.line_cnt, bus.int_n);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.int_n !== 1'b1 || bus.line_cnt !== 9'd0) begin
      n_err++;
      $display("FAIL mid_reset_async: int_n %b line %0d want 1/0", bus.int_n, bus.line_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cyc(1, 0, 0, 0, 0);
    n_cmp++;
    if (bus.line_cnt !== 9'd1 || bus.frame_start !== 1'b0) begin
      n_err++;
      $display("FAIL mid_first_line: line %0d fs %b want 1/0", bus.line_cnt, bus.frame_start);
    end
  endtask

  task automatic test_random;
    int  ln = 0, n = 0;
    bit  vb = 0, vs = 0, vp = 0, act = 0, fs;
    bit  ls, hs, hi, ack, ce;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      ls  = ($urandom_range(3) == 0);
      hs  = ($urandom_range(3) == 0);
      hi  = (ln == 319) ? ($urandom_range(1) == 0) : ($urandom_range(7) == 0);
      ack = ($urandom_range(15) == 0);
      ce  = ($urandom_range(1) == 0);
      fs  = ls && (ln == 319);
      if (hs) begin
        if (ln == 0) vb = 1; else if (ln == 32) vb = 0;
        if (ln == 8) vs = 1; else if (ln == 12) vs = 0;
        if (ln == 80) vp = 1; else if (ln == 272) vp = 0;
      end
      if (hi && ln == 319) begin
        act = 1;
        n = 0;
      end else if (act) begin
        if (ack) act = 0;
        else if (ce) begin
          n++;
          if (n == 64) act = 0;
        end
      end
      if (ls) ln = (ln + 1) % 320;
      cyc(ls, hs, hi, ack, ce);
      n_cmp++;
      if ({bus.line_cnt, bus.vblank, bus.vsync, bus.vpix, bus.int_n, bus.frame_start} !==
          {9'(ln), vb, vs, vp, !act, fs}) begin
        n_err++;
        if (n_err < 20)
          $display("FAIL random_cycle%0d: got line %0d vb%b vs%b vp%b int_n%b fs%b want line %0d vb%b vs%b vp%b int_n%b fs%b",
                   k, bus.line_cnt, bus.vblank, bus.vsync, bus.vpix, bus.int_n, bus.frame_start,
                   ln, vb, vs, vp, !act, fs);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.line_start  = 1'b0;
    bus.hsync_start = 1'b0;
    bus.hint_start  = 1'b0;
    bus.int_ack     = 1'b0;
    bus.cend        = 1'b0;
    @(negedge clk);
    test_reset();
    test_frame_wrap();
    test_flags();
    test_int_timeout();
    test_int_ack();
    test_int_collision();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
